// File: rtl/key_loader_pkg.sv
// Shared types and constants for the serial key loader and the locked-netlist wrapper.
package key_loader_pkg;

    localparam int KEY_WIDTH_DEF = 8;
    localparam int MAX_RETRY_DEF = 3;
    localparam int BIT_CNT_W     = $clog2(KEY_WIDTH_DEF + 1);
    localparam int RETRY_W       = $clog2(MAX_RETRY_DEF + 1);

    localparam logic [KEY_WIDTH_DEF-1:0] DEFAULT_DECOY_KEY = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESTART = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_LOADED  = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    function automatic logic parity_fold(input logic acc, input logic din);
        return acc ^ din;
    endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Shadow key register, bit counter and running even-parity accumulator for the serial key stream.
module key_shift_reg
    import key_loader_pkg::*;
#(
    parameter int KEY_WIDTH = KEY_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 accept,
    input  logic                 data_bit,
    output logic [KEY_WIDTH-1:0] shadow,
    output logic                 last_bit,
    output logic                 parity_ok
);

    localparam int CNT_W = $clog2(KEY_WIDTH + 1);

    logic [CNT_W-1:0] bit_cnt_r;
    logic             parity_acc_r;

    // Shift accepted bits LSB first; the accept at count KEY_WIDTH is the parity bit only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow       <= {KEY_WIDTH{1'b0}};
            bit_cnt_r    <= {CNT_W{1'b0}};
            parity_acc_r <= 1'b0;
        end else if (clear) begin
            shadow       <= {KEY_WIDTH{1'b0}};
            bit_cnt_r    <= {CNT_W{1'b0}};
            parity_acc_r <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
                if (bit_cnt_r == CNT_W'(i)) begin
                    shadow[i] <= data_bit;
                end
            end
            bit_cnt_r    <= bit_cnt_r + CNT_W'(1);
            parity_acc_r <= parity_fold(parity_acc_r, data_bit);
        end
    end

    assign last_bit  = (bit_cnt_r == CNT_W'(KEY_WIDTH));
    assign parity_ok = ~parity_acc_r;

endmodule

// File: rtl/key_loader.sv
// Fetches the unlock key serially from NVM, verifies even parity with bounded retries,
// and exposes it to the locked core only after verification; a decoy key is driven otherwise.
module key_loader
    import key_loader_pkg::*;
#(
    parameter int                   KEY_WIDTH = KEY_WIDTH_DEF,
    parameter logic [KEY_WIDTH-1:0] DECOY_KEY = DEFAULT_DECOY_KEY,
    parameter int                   MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 nvm_restart,
    output logic                 nvm_req,
    input  logic                 nvm_valid,
    input  logic                 nvm_bit,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 error
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t               state_r;
    state_t               state_next_s;
    logic [RW-1:0]        retry_cnt_r;
    logic                 accept_s;
    logic [KEY_WIDTH-1:0] shadow_s;
    logic                 last_bit_s;
    logic                 parity_ok_s;

    assign nvm_restart = (state_r == ST_RESTART);
    assign nvm_req     = (state_r == ST_SHIFT);
    assign busy        = (state_r == ST_RESTART) || (state_r == ST_SHIFT) || (state_r == ST_CHECK);
    assign accept_s    = nvm_req && nvm_valid;

    key_shift_reg #(
        .KEY_WIDTH (KEY_WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (nvm_restart),
        .accept    (accept_s),
        .data_bit  (nvm_bit),
        .shadow    (shadow_s),
        .last_bit  (last_bit_s),
        .parity_ok (parity_ok_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; LOADED and FAIL only leave through reset
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RESTART;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RESTART: state_next_s = ST_SHIFT;
            ST_SHIFT: begin
                if (accept_s && last_bit_s) begin
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                if (parity_ok_s) begin
                    state_next_s = ST_LOADED;
                end else if (retry_cnt_r == RW'(MAX_RETRY)) begin
                    state_next_s = ST_FAIL;
                end else begin
                    state_next_s = ST_RESTART;
                end
            end
            ST_LOADED: state_next_s = ST_LOADED;
            ST_FAIL:   state_next_s = ST_FAIL;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Retry count and key outputs; key_out only ever changes on a verified CHECK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt_r <= {RW{1'b0}};
            key_out     <= DECOY_KEY;
            key_valid   <= 1'b0;
            error       <= 1'b0;
        end else if (state_r == ST_CHECK) begin
            if (parity_ok_s) begin
                key_out   <= shadow_s;
                key_valid <= 1'b1;
            end else if (retry_cnt_r == RW'(MAX_RETRY)) begin
                error <= 1'b1;
            end else begin
                retry_cnt_r <= retry_cnt_r + RW'(1);
            end
        end
    end

endmodule
